des_implementation: RTL and testbench
=====================================

DES_IMPLEMENTATION -- requirements
Module: des_implementation

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to encrypt; sampled on rising clk only while idle.
REQ-005 message  input  64 [64:1]  plaintext block.
REQ-006 key  input  64 [64:1]  DES key, including parity bits.
REQ-007 enigma  output  64 [64:1]  ciphertext register.
REQ-008 busy  output  1  high while a block is being processed.
REQ-009 done  output  1  one-cycle pulse when enigma is updated with a new result.

Function
REQ-010 The block SHALL implement single-block DES encryption per FIPS 46-3: IP, 16 Feistel rounds (E, S1-S8, P), PC-1/PC-2 key schedule with shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, final swap, and IP^-1.
REQ-011 FIPS bit n (1 = leftmost) SHALL map to vector index 65-n, so index 64 is the MSB and the first bit.
REQ-012 Key parity bits (FIPS bits 8,16,...,64) SHALL be ignored.
REQ-013 At a rising edge with start=1 and busy=0, the block SHALL latch IP(message) into L/R and PC-1(key) into C/D, set busy=1, and set the round counter to 1. This is edge k.
REQ-014 Edges k+1 through k+16 SHALL each execute exactly one round, with the subkey derived from the shifted C/D for that round.
REQ-015 At edge k+17 the block SHALL load enigma <= IP^-1(R16||L16), pulse done=1 for that cycle only, and return busy to 0.
REQ-016 Total latency SHALL be 17 clock cycles from the start edge to done.
REQ-017 The earliest new start is accepted at the edge after done; back-to-back throughput is one block per 18 cycles.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 message and key SHALL be sampled only at the start edge; later changes have no effect on the block in flight.
REQ-020 enigma SHALL hold its value between completions and SHALL change only at a done edge or on reset.
REQ-021 The datapath SHALL contain one round's combinational logic reused iteratively, with no unrolled pipeline.

Reset
REQ-022 While rst=1, the block SHALL immediately drive enigma=0, busy=0, done=0, and clear L/R, C/D and the round counter.
REQ-023 Reset asserted mid-operation SHALL abort the block with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.
REQ-024 While rst=1, start SHALL be ignored.

Verification
REQ-025 key=133457799BBCDFF1, message=0123456789ABCDEF, one-cycle start -> done exactly 17 cycles later with enigma=85E813540F0AB405.
REQ-026 key=0000000000000000, message=0000000000000000 -> enigma=8CA64DE9C1B123A7; repeat with key=0101010101010101 (parity-only difference) -> same enigma.
REQ-027 key=0101010101010101, message=95F8A5E5DD31D900 -> enigma=8000000000000000.
REQ-028 Start the REQ-025 vector, change message/key and pulse start again at cycle 5 -> single done at cycle 17 with enigma=85E813540F0AB405; busy stays 1 throughout.
REQ-029 Start the REQ-025 vector, assert rst at cycle 8 -> enigma=0, busy=0, no done; after release, restart with the REQ-026 zero vector -> 8CA64DE9C1B123A7 after 17 cycles.
REQ-030 Two back-to-back blocks (REQ-025 then REQ-027) -> two done pulses 18 cycles apart with the correct ciphertexts, and enigma stable between the pulses.

Source files
------------

// File: rtl/des_implementation.sv
// DES single-block encryptor (FIPS 46-3), one Feistel round per clock.
// Vectors use [N:1] ranges so FIPS bit n sits at index N+1-n (index N is bit 1).
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    encrypt request, honoured only while idle
//   message  64-bit plaintext, sampled on the start edge
//   key      64-bit key incl. parity bits, sampled on the start edge
//   enigma   registered ciphertext, updated only on completion
//   busy     high from the start edge until the result edge
//   done     one-cycle pulse coinciding with an enigma update
module des_implementation (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [64:1] message,
  input  logic [64:1] key,
  output logic [64:1] enigma,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ROUND_W    = 5;
  localparam int unsigned LAST_ROUND = 16;

  // Permutation tables: entry j names the FIPS input bit feeding output bit j+1.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // PC-1 never references bits 8,16,...,64, which discards key parity.
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S-boxes indexed by {row, column}, row-major as published.
  localparam logic [3:0] SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_t;

  state_t               state;
  logic [32:1]          l, r;
  logic [28:1]          c, d;
  logic [ROUND_W-1:0]   round;
  logic [28:1]          c_rot, d_rot;
  logic [48:1]          subkey;
  logic [32:1]          f_out;

  function automatic logic [64:1] perm_ip(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[7'(64 - j)] = x[7'(65 - IP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [64:1] perm_fp(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[7'(64 - j)] = x[7'(65 - FP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [56:1] perm_pc1(input logic [64:1] x);
    logic [56:1] y;
    y = '0;
    for (int j = 0; j < 56; j++) y[6'(56 - j)] = x[7'(65 - PC1_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [48:1] perm_pc2(input logic [56:1] x);
    logic [48:1] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[6'(48 - j)] = x[6'(57 - PC2_T[6'(j)])];
    return y;
  endfunction

  // Round function f(R, K) = P(S(E(R) xor K)).
  function automatic logic [32:1] feistel(input logic [32:1] rin, input logic [48:1] k);
    logic [48:1] x;
    logic [32:1] s;
    logic [32:1] p;
    logic [6:1]  b;
    x = '0;
    s = '0;
    p = '0;
    for (int j = 0; j < 48; j++) x[6'(48 - j)] = rin[6'(33 - E_T[6'(j)])];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b = x[6'(48 - 6 * i) -: 6];
      // Outer bits select the row, inner four the column.
      s[6'(32 - 4 * i) -: 4] = SBOX_T[3'(i)][{b[6], b[1], b[5:2]}];
    end
    for (int j = 0; j < 32; j++) p[6'(32 - j)] = s[6'(33 - P_T[5'(j)])];
    return p;
  endfunction

  // Single shared round: rotate C/D for the current round, then derive subkey and f.
  always_comb begin
    c_rot  = {c[26:1], c[28:27]};
    d_rot  = {d[26:1], d[28:27]};
    if (round == ROUND_W'(1) || round == ROUND_W'(2) ||
        round == ROUND_W'(9) || round == ROUND_W'(16)) begin
      c_rot = {c[27:1], c[28]};
      d_rot = {d[27:1], d[28]};
    end
    subkey = perm_pc2({c_rot, d_rot});
    f_out  = feistel(r, subkey);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      l      <= '0;
      r      <= '0;
      c      <= '0;
      d      <= '0;
      round  <= '0;
      enigma <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            {l, r} <= perm_ip(message);
            {c, d} <= perm_pc1(key);
            round  <= ROUND_W'(1);
            busy   <= 1'b1;
            state  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          l     <= r;
          r     <= l ^ f_out;
          c     <= c_rot;
          d     <= d_rot;
          round <= round + ROUND_W'(1);
          if (round == ROUND_W'(LAST_ROUND)) state <= ST_FINAL;
        end
        ST_FINAL: begin
          // Halves are swapped after round 16 before the inverse permutation.
          enigma <= perm_fp({r, l});
          done   <= 1'b1;
          busy   <= 1'b0;
          round  <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_implementation.sv
// Self-checking bench for des_implementation: directed FIPS vectors, timing,
// start-while-busy, mid-block reset, back-to-back blocks and random blocks
// compared against a word-level DES model.
module tb_des_implementation;

  logic        clk;
  logic        rst;
  logic        start;
  logic [64:1] message;
  logic [64:1] key;
  logic [64:1] enigma;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  des_implementation dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .message (message),
    .key     (key),
    .enigma  (enigma),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables (FIPS numbering, output bit order).
  int ip_t[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                  64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int fp_t[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                  37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int e_t[$]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                  16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t[$]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sbox_t[$] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Gather bits MSB-first: output bit j+1 is FIPS bit t[j] of the w-bit input.
  function automatic logic [63:0] perm(input logic [63:0] x, input int w, input int t[$]);
    logic [63:0] y = '0;
    foreach (t[j]) y = (y << 1) | ((x >> (w - t[j])) & 64'd1);
    return y;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] m, input logic [63:0] k);
    logic [63:0] x, cd, c, d, l, r, er, s, f, tmp;
    int sh, six, row, col;
    x  = perm(m, 64, ip_t);
    l  = x >> 32;
    r  = x & 64'hFFFF_FFFF;
    cd = perm(k, 64, pc1_t);
    c  = cd >> 28;
    d  = cd & 64'h0FFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c  = ((c << sh) | (c >> (28 - sh))) & 64'h0FFF_FFFF;
      d  = ((d << sh) | (d >> (28 - sh))) & 64'h0FFF_FFFF;
      er = perm(r, 32, e_t) ^ perm((c << 28) | d, 56, pc2_t);
      s  = '0;
      for (int b = 0; b < 8; b++) begin
        six = int'((er >> (42 - 6 * b)) & 64'd63);
        row = ((six >> 5) << 1) | (six & 1);
        col = (six >> 1) & 15;
        s   = (s << 4) | 64'(sbox_t[b * 64 + row * 16 + col]);
      end
      f   = perm(s, 32, p_t);
      tmp = r;
      r   = l ^ f;
      l   = tmp;
    end
    return perm((r << 32) | l, 64, fp_t);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one block, optionally re-pulse start with altered inputs at cycle
  // 'inject' (0 = none), and wait (bounded) for done.
  task automatic run_block(input string tag, input logic [63:0] msg, input logic [63:0] kk,
                           input logic [63:0] exp, input int inject);
    logic [63:0] hold;
    int          cycles;
    bit          stable, busy_ok;
    hold    = enigma;
    message = msg;
    key     = kk;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({tag, ".busy_at_start"}, 64'(busy), 64'd1);
    cycles  = 0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
      if (cycles == inject) begin
        start   = 1'b1;
        message = ~message;
        key     = key ^ {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      if (done !== 1'b1) begin
        if (enigma !== hold) stable = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(cycles), 64'd17);
    check({tag, ".enigma"}, enigma, exp);
    check({tag, ".enigma_held"}, 64'(stable), 64'd1);
    check({tag, ".busy_held"}, 64'(busy_ok), 64'd1);
  endtask

  localparam logic [63:0] K25 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] M25 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C25 = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] C26 = 64'h8CA6_4DE9_C1B1_23A7;
  localparam logic [63:0] K27 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] M27 = 64'h95F8_A5E5_DD31_D900;
  localparam logic [63:0] C27 = 64'h8000_0000_0000_0000;

  initial begin
    logic [63:0] rm, rk;
    int          dcount, bcount;
    rst = 1'b1; start = 1'b0; message = '0; key = '0;
    #2;
    check("reset.enigma", enigma, 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_block("v025", M25, K25, C25, 0);
    tick();
    check("v025.done_pulse", 64'(done), 64'd0);
    check("v025.busy_end", 64'(busy), 64'd0);
    check("v025.enigma_after", enigma, C25);

    run_block("v026_zero", 64'd0, 64'd0, C26, 0);
    run_block("v026_parity", 64'd0, K27, C26, 0);
    run_block("v027", M27, K27, C27, 0);
    tick();

    // Second start mid-block must be ignored.
    run_block("v028", M25, K25, C25, 5);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    check("v028.extra_done", 64'(dcount), 64'd0);
    check("v028.busy_idle", 64'(busy), 64'd0);

    // Reset eight cycles into a block, with start held during reset.
    message = M25; key = K25; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("v029.enigma", enigma, 64'd0);
    check("v029.busy", 64'(busy), 64'd0);
    check("v029.done", 64'(done), 64'd0);
    start = 1'b1;
    tick();
    tick();
    check("v029.busy_in_reset", 64'(busy), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) dcount++;
      if (busy === 1'b1) bcount++;
    end
    check("v029.no_done", 64'(dcount), 64'd0);
    check("v029.no_busy", 64'(bcount), 64'd0);
    run_block("v029_restart", 64'd0, 64'd0, C26, 0);

    // Back-to-back: second start on the edge right after done.
    tick();
    run_block("v030_a", M25, K25, C25, 0);
    run_block("v030_b", M27, K27, C27, 0);

    // Random blocks against the reference model, some with ignored re-starts.
    for (int n = 0; n < 12; n++) begin
      rm = {$urandom, $urandom};
      rk = {$urandom, $urandom};
      run_block($sformatf("rand%0d", n), rm, rk, des_ref(rm, rk), int'($urandom_range(0, 16)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
